mvm_sched: RTL and testbench

MVM_SCHED -- requirements
Module: mvm_sched

---
 rtl/mvm_sched_pkg.sv | 26 ++
 rtl/mvm_obuf.sv | 70 +++++++
 rtl/mvm_sched.sv | 184 ++++++++++++++++++
 tb/tb_mvm_sched.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mvm_sched_pkg.sv
// Shared types and constants for the matrix-vector engine scheduler.
package mvm_sched_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LPULSE,
        S_LDATA,
        S_START,
        S_WAIT,
        S_COLLECT,
        S_DRAIN
    } state_e;

    typedef enum logic [1:0] {
        OP_LOADM   = 2'b00,
        OP_LOADV   = 2'b01,
        OP_COMPUTE = 2'b10,
        OP_RSVD    = 2'b11
    } op_e;

    localparam int unsigned ERR_W        = 3;
    localparam int unsigned ERR_UNDERRUN = 0;
    localparam int unsigned ERR_SEQ      = 1;
    localparam int unsigned ERR_TMO      = 2;

endpackage

// File: rtl/mvm_obuf.sv
// K-entry result buffer; rd_data is a registered prefetch of the entry at the read pointer.
module mvm_obuf #(
    parameter int unsigned K = 12,
    parameter int unsigned W = 24
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clr,
    input  logic         wr_en,
    input  logic [W-1:0] wr_data,
    input  logic         rd_en,
    output logic [W-1:0] rd_data,
    output logic         empty,
    output logic         full
);
    localparam int unsigned PW = (K > 1) ? $clog2(K) : 1;
    localparam int unsigned NW = $clog2(K + 1);

    logic [W-1:0]  mem_q [K];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [NW-1:0] count_q, count_d;
    logic [W-1:0]  rd_data_q, rd_data_d;
    logic          do_wr, do_rd;

    assign empty   = (count_q == '0);
    assign full    = (count_q == NW'(K));
    assign rd_data = rd_data_q;

    always_comb begin
        do_wr     = wr_en && !full;
        do_rd     = rd_en && !empty;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;
        if (do_wr) wr_ptr_d = (wr_ptr_q == PW'(K - 1)) ? '0 : wr_ptr_q + PW'(1);
        if (do_rd) rd_ptr_d = (rd_ptr_q == PW'(K - 1)) ? '0 : rd_ptr_q + PW'(1);
        case ({do_wr, do_rd})
            2'b10:   count_d = count_q + NW'(1);
            2'b01:   count_d = count_q - NW'(1);
            default: count_d = count_q;
        endcase
        if (clr) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end
        // Bypass so the head entry is visible the cycle after it is written.
        rd_data_d = (do_wr && (wr_ptr_q == rd_ptr_d)) ? wr_data : mem_q[rd_ptr_d];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            rd_data_q <= '0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            rd_data_q <= rd_data_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_wr) mem_q[wr_ptr_q] <= wr_data;
    end

endmodule

// File: rtl/mvm_sched.sv
// Command scheduler for a non-stallable matrix-vector engine: loads, compute, result collect and drain.
module mvm_sched
    import mvm_sched_pkg::*;
#(
    parameter int unsigned K   = 12,
    parameter int unsigned B   = 12,
    parameter int unsigned TMO = K * K + 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [B-1:0]     in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [2*B-1:0]   out_data,
    output logic             mvm_loadMatrix,
    output logic             mvm_loadVector,
    output logic             mvm_start,
    output logic [B-1:0]     mvm_data_in,
    input  logic             mvm_done,
    input  logic [2*B-1:0]   mvm_data_out,
    output logic             busy,
    output logic [2:0]       err
);
    localparam int unsigned CW = $clog2(K * K + 1);
    localparam int unsigned TW = $clog2(TMO + 1);

    state_e           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [TW-1:0]    tmo_q, tmo_d;
    logic             ld_mat_q, ld_mat_d;
    logic             m_ok_q, m_ok_d;
    logic             v_ok_q, v_ok_d;
    logic [ERR_W-1:0] err_q, err_d;
    logic             load_m_q, load_m_d;
    logic             load_v_q, load_v_d;
    logic             start_q, start_d;
    logic             busy_q, busy_d;
    logic [CW-1:0]    ld_last;
    logic             obuf_wr, obuf_rd, obuf_empty, obuf_full;

    assign cmd_ready      = (state_q == S_IDLE);
    assign in_ready       = (state_q == S_LDATA);
    assign out_valid      = (state_q == S_DRAIN);
    // The engine samples the load word in the same cycle it is presented.
    assign mvm_data_in    = (state_q == S_LDATA && in_valid) ? in_data : '0;
    assign mvm_loadMatrix = load_m_q;
    assign mvm_loadVector = load_v_q;
    assign mvm_start      = start_q;
    assign busy           = busy_q;
    assign err            = err_q;

    assign ld_last = ld_mat_q ? CW'(K * K - 1) : CW'(K - 1);
    assign obuf_wr = (state_q == S_COLLECT) && !obuf_full;
    assign obuf_rd = (state_q == S_DRAIN) && out_ready;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        tmo_d    = tmo_q;
        ld_mat_d = ld_mat_q;
        m_ok_d   = m_ok_q;
        v_ok_d   = v_ok_q;
        err_d    = err_q;

        if (mvm_done && state_q != S_WAIT) err_d[ERR_SEQ] = 1'b1;

        case (state_q)
            S_IDLE: begin
                if (cmd_valid) begin
                    case (op_e'(cmd_op))
                        OP_LOADM: begin
                            ld_mat_d = 1'b1;
                            state_d  = S_LPULSE;
                        end
                        OP_LOADV: begin
                            ld_mat_d = 1'b0;
                            state_d  = S_LPULSE;
                        end
                        OP_COMPUTE: begin
                            if (m_ok_q && v_ok_q) state_d = S_START;
                            else                  err_d[ERR_SEQ] = 1'b1;
                        end
                        default: err_d[ERR_SEQ] = 1'b1;
                    endcase
                end
            end
            S_LPULSE: state_d = S_LDATA;
            S_LDATA: begin
                // Missing words still consume a slot: the engine cannot stall.
                if (!in_valid) err_d[ERR_UNDERRUN] = 1'b1;
                if (cnt_q == ld_last) begin
                    state_d = S_IDLE;
                    if (ld_mat_q) m_ok_d = 1'b1;
                    else          v_ok_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_START: state_d = S_WAIT;
            S_WAIT: begin
                if (mvm_done) begin
                    state_d = S_COLLECT;
                end else if (tmo_q == TW'(TMO - 1)) begin
                    err_d[ERR_TMO] = 1'b1;
                    state_d        = S_IDLE;
                end else begin
                    tmo_d = tmo_q + TW'(1);
                end
            end
            S_COLLECT: begin
                if (cnt_q == CW'(K - 1)) state_d = S_DRAIN;
                else                     cnt_d   = cnt_q + CW'(1);
            end
            S_DRAIN: begin
                if (obuf_rd) begin
                    if (cnt_q == CW'(K - 1)) state_d = S_IDLE;
                    else                     cnt_d   = cnt_q + CW'(1);
                end else if (obuf_empty) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (state_d != state_q) begin
            cnt_d = '0;
            tmo_d = '0;
        end

        load_m_d = (state_d == S_LPULSE) && ld_mat_d;
        load_v_d = (state_d == S_LPULSE) && !ld_mat_d;
        start_d  = (state_d == S_START);
        busy_d   = (state_d != S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            tmo_q    <= '0;
            ld_mat_q <= 1'b0;
            m_ok_q   <= 1'b0;
            v_ok_q   <= 1'b0;
            err_q    <= '0;
            load_m_q <= 1'b0;
            load_v_q <= 1'b0;
            start_q  <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            tmo_q    <= tmo_d;
            ld_mat_q <= ld_mat_d;
            m_ok_q   <= m_ok_d;
            v_ok_q   <= v_ok_d;
            err_q    <= err_d;
            load_m_q <= load_m_d;
            load_v_q <= load_v_d;
            start_q  <= start_d;
            busy_q   <= busy_d;
        end
    end

    mvm_obuf #(
        .K (K),
        .W (2 * B)
    ) u_obuf (
        .clk     (clk),
        .reset   (reset),
        .clr     (state_q == S_START),
        .wr_en   (obuf_wr),
        .wr_data (mvm_data_out),
        .rd_en   (obuf_rd),
        .rd_data (out_data),
        .empty   (obuf_empty),
        .full    (obuf_full)
    );

endmodule

// File: tb/tb_mvm_sched.sv
// Directed bench for mvm_sched with K=2, B=12 (TMO=20); the engine is a scripted stub.
module tb_mvm_sched;
    localparam int unsigned K   = 2;
    localparam int unsigned B   = 12;
    localparam int unsigned TMO = K * K + 16;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic [1:0]    cmd_op = 2'b00;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [B-1:0]  in_data = '0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [2*B-1:0] out_data;
    logic          mvm_loadMatrix, mvm_loadVector, mvm_start;
    logic [B-1:0]  mvm_data_in;
    logic          mvm_done = 1'b0;
    logic [2*B-1:0] mvm_data_out = '0;
    logic          busy;
    logic [2:0]    err;

    int nchk = 0;
    int nerr = 0;

    mvm_sched #(.K(K), .B(B)) dut (
        .clk            (clk),
        .reset          (reset),
        .cmd_valid      (cmd_valid),
        .cmd_ready      (cmd_ready),
        .cmd_op         (cmd_op),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .in_data        (in_data),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_data       (out_data),
        .mvm_loadMatrix (mvm_loadMatrix),
        .mvm_loadVector (mvm_loadVector),
        .mvm_start      (mvm_start),
        .mvm_data_in    (mvm_data_in),
        .mvm_done       (mvm_done),
        .mvm_data_out   (mvm_data_out),
        .busy           (busy),
        .err            (err)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit               ldm;
        logic [0:3][11:0] m;
        logic [0:3][11:0] v;
        int               lat;
        logic [7:0]       rdy;
        logic [23:0]      y0;
        logic [23:0]      y1;
    } vec_t;

    vec_t tbl [4];

    function automatic vec_t mk(input bit ldm, input logic [0:3][11:0] m, input logic [0:3][11:0] v,
                                input int lat, input logic [7:0] rdy, input logic [23:0] y0,
                                input logic [23:0] y1);
        vec_t r;
        r.ldm = ldm; r.m = m; r.v = v; r.lat = lat; r.rdy = rdy; r.y0 = y0; r.y1 = y1;
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic reset_dut();
        @(negedge clk);
        reset = 1'b1; cmd_valid = 1'b0; in_valid = 1'b0; out_ready = 1'b0; mvm_done = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic do_load(input bit mat, input logic [0:3][11:0] w, input logic [3:0] mask);
        int n = mat ? 4 : 2;
        @(negedge clk);
        cmd_valid = 1'b1; cmd_op = mat ? 2'b00 : 2'b01;
        #1 chk("ld_cmd_ready", cmd_ready, 1);
        @(negedge clk);
        cmd_valid = 1'b0;
        #1;
        chk("ld_pulse_m", mvm_loadMatrix, mat);
        chk("ld_pulse_v", mvm_loadVector, !mat);
        chk("ld_no_start", mvm_start, 0);
        chk("ld_pulse_in_ready", in_ready, 0);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            in_valid = mask[i]; in_data = w[i];
            #1;
            chk("ld_in_ready", in_ready, 1);
            chk("ld_data_in", mvm_data_in, mask[i] ? w[i] : 12'd0);
            chk("ld_pulse_once", mvm_loadMatrix | mvm_loadVector, 0);
        end
        @(negedge clk);
        in_valid = 1'b0; in_data = '0;
        #1;
        chk("ld_end_idle", cmd_ready, 1);
        chk("ld_end_in_ready", in_ready, 0);
    endtask

    task automatic run_compute(input int lat, input logic [7:0] rdy, input logic [23:0] y0,
                               input logic [23:0] y1, input bit abort);
        logic [23:0] y [2];
        int e = 0;
        y[0] = y0; y[1] = y1;
        @(negedge clk);
        cmd_valid = 1'b1; cmd_op = 2'b10;
        #1 chk("cmp_cmd_ready", cmd_ready, 1);
        @(negedge clk);
        cmd_valid = 1'b0;
        #1;
        chk("cmp_start", mvm_start, 1);
        chk("cmp_busy", busy, 1);
        repeat (lat) begin
            @(negedge clk);
            #1 chk("cmp_wait_nostart", mvm_start, 0);
        end
        @(negedge clk);
        mvm_done = 1'b1;
        #1 chk("cmp_done_no_valid", out_valid, 0);
        @(negedge clk);
        mvm_done = 1'b0; mvm_data_out = y[0];
        #1 chk("col0_no_valid", out_valid, 0);
        @(negedge clk);
        mvm_data_out = y[1];
        #1 chk("col1_no_valid", out_valid, 0);
        @(negedge clk);
        mvm_data_out = '0;
        if (abort) begin
            out_ready = 1'b0;
            #1 chk("abort_pre_valid", out_valid, 1);
            reset = 1'b1;
            @(negedge clk);
            reset = 1'b0;
            #1;
            chk("abort_out_valid", out_valid, 0);
            chk("abort_busy", busy, 0);
            return;
        end
        for (int c = 0; c < 8; c++) begin
            if (c > 0) @(negedge clk);
            out_ready = rdy[c];
            #1;
            if (e < 2) begin
                chk("drain_valid", out_valid, 1);
                chk("drain_data", out_data, y[e]);
                if (rdy[c]) e++;
            end else begin
                chk("drain_done_idle", out_valid, 0);
                chk("drain_done_ready", cmd_ready, 1);
                break;
            end
        end
        out_ready = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0] = mk(1'b1, {12'd1, 12'd2, 12'd3, 12'd4}, {12'd5, 12'd6, 12'd0, 12'd0},
                    1, 8'hFF, 24'd17, 24'd39);
        tbl[1] = mk(1'b1, {12'hFFF, 12'h000, 12'h002, 12'hFFD}, {12'd7, 12'hFFE, 12'd0, 12'd0},
                    3, 8'b0000_1001, 24'hFFFFF9, 24'd20);
        tbl[2] = mk(1'b0, {12'd0, 12'd0, 12'd0, 12'd0}, {12'd1, 12'd2, 12'd0, 12'd0},
                    0, 8'b0000_0101, 24'hFFFFFF, 24'hFFFFFC);
        tbl[3] = mk(1'b1, {12'h7FF, 12'h800, 12'h001, 12'h001}, {12'h7FF, 12'h001, 12'd0, 12'd0},
                    5, 8'b0000_0110, 24'h3FE801, 24'h000800);

        reset_dut();
        #1;
        chk("rst_cmd_ready", cmd_ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_err", err, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_pulses", {mvm_loadMatrix, mvm_loadVector, mvm_start}, 0);
        chk("rst_data_in", mvm_data_in, 0);

        // Compute with nothing loaded.
        @(negedge clk);
        cmd_valid = 1'b1; cmd_op = 2'b10;
        @(negedge clk);
        cmd_valid = 1'b0;
        #1;
        chk("noload_start", mvm_start, 0);
        chk("noload_busy", busy, 0);
        chk("noload_err", err, 3'b010);
        @(negedge clk);
        #1 chk("noload_busy2", busy, 0);

        // Reserved opcode.
        reset_dut();
        @(negedge clk);
        cmd_valid = 1'b1; cmd_op = 2'b11;
        @(negedge clk);
        cmd_valid = 1'b0;
        #1;
        chk("rsvd_err", err, 3'b010);
        chk("rsvd_pulses", {mvm_loadMatrix, mvm_loadVector, mvm_start}, 0);
        chk("rsvd_busy", busy, 0);

        reset_dut();
        for (int t = 0; t < 4; t++) begin
            if (tbl[t].ldm) do_load(1'b1, tbl[t].m, 4'hF);
            do_load(1'b0, tbl[t].v, 4'h3);
            run_compute(tbl[t].lat, tbl[t].rdy, tbl[t].y0, tbl[t].y1, 1'b0);
            chk("vec_err_clean", err, 0);
        end

        // Missing word during a vector load.
        reset_dut();
        do_load(1'b0, {12'd9, 12'd8, 12'd0, 12'd0}, 4'b0010);
        chk("underrun_err", err, 3'b001);

        // Engine never completes.
        reset_dut();
        do_load(1'b1, {12'd1, 12'd1, 12'd1, 12'd1}, 4'hF);
        do_load(1'b0, {12'd1, 12'd1, 12'd0, 12'd0}, 4'h3);
        @(negedge clk);
        cmd_valid = 1'b1; cmd_op = 2'b10;
        @(negedge clk);
        cmd_valid = 1'b0;
        #1 chk("tmo_start", mvm_start, 1);
        for (int i = 0; i < int'(TMO); i++) begin
            @(negedge clk);
            #1;
            chk("tmo_wait_busy", busy, 1);
            chk("tmo_wait_valid", out_valid, 0);
            chk("tmo_wait_err", err[2], 0);
        end
        @(negedge clk);
        #1;
        chk("tmo_idle", busy, 0);
        chk("tmo_err", err, 3'b100);
        chk("tmo_out_valid", out_valid, 0);

        // Stray completion outside WAIT.
        @(negedge clk);
        mvm_done = 1'b1;
        @(negedge clk);
        mvm_done = 1'b0;
        #1;
        chk("stray_done_err", err, 3'b110);
        chk("stray_done_valid", out_valid, 0);

        // Reset in the middle of DRAIN clears loaded state.
        reset_dut();
        do_load(1'b1, {12'd1, 12'd2, 12'd3, 12'd4}, 4'hF);
        do_load(1'b0, {12'd5, 12'd6, 12'd0, 12'd0}, 4'h3);
        run_compute(1, 8'hFF, 24'd17, 24'd39, 1'b1);
        @(negedge clk);
        cmd_valid = 1'b1; cmd_op = 2'b10;
        @(negedge clk);
        cmd_valid = 1'b0;
        #1;
        chk("post_abort_start", mvm_start, 0);
        chk("post_abort_err", err, 3'b010);
        chk("post_abort_valid", out_valid, 0);

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
